reg_register_evt_status: RTL and testbench
==========================================

Name: reg_register_evt_status

Overview:
- Parametrised status register for up to REG_WIDTH event/status sources.
- Each bit is either a live read-only level or a sticky event latched on a rising edge and cleared by write-1-to-clear.
- Produces a masked, registered interrupt and one-cycle read/write strobes.
- Sits on the register-bank select/read/write bus, like other field-based registers.

Parameters:
- REG_WIDTH, 32, register data width.
- EVT_NUM, 8, number of status bits; 1 <= EVT_NUM <= REG_WIDTH.
- STICKY_MASK, {EVT_NUM{1'b1}}, per bit: 1 = sticky rising-edge event (W1C); 0 = live level (RO).
- IRQ_MASK_RST, {EVT_NUM{1'b0}}, reset value of the internal interrupt-enable mask.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- evt_in  in  EVT_NUM  raw status/event levels, synchronous to clk
- irq_en_wr  in  1  load irq_en_data into the interrupt mask this cycle
- irq_en_data  in  EVT_NUM  new interrupt mask
- reg_wr_sel  in  1  register select
- reg_wr_rd  in  1  1 = write, 0 = read
- reg_wr_data  in  REG_WIDTH  write data; 1s clear sticky bits
- reg_rd_out  out  REG_WIDTH  read data, combinational
- status_rd  out  1  one-cycle pulse, registered read strobe
- status_wr  out  1  one-cycle pulse, registered write strobe
- irq  out  1  registered interrupt, level

Behaviour:
- Reset is asynchronous (rst_n low). At reset:
  - sticky status = 0; edge-detect history evt_q = 0; irq mask = IRQ_MASK_RST.
  - irq = 0; status_rd = 0; status_wr = 0.
  - reg_rd_out reflects live bits only.
- Strobe decode:
  - reg_write = sel & wr_rd.
  - reg_read = sel & ~wr_rd.
- status_rd and status_wr are reg_read and reg_write delayed by exactly 1 cycle.
- Edge detect:
  - evt_q <= evt_in every cycle.
  - rise[i] = evt_in[i] & ~evt_q[i].
  - An input already high at reset release produces a rise in the first cycle after reset.
- Sticky bit i (STICKY_MASK[i] = 1), next-state priority:
  1. rise[i] -> 1.
  2. Else reg_write & reg_wr_data[i] -> 0.
  3. Else hold.
  - A set coincident with a W1C clear leaves the bit at 1; the event is never lost.
- Live bit i (STICKY_MASK[i] = 0):
  - Read value = evt_in[i]; there is no storage.
  - Writes are ignored; the bit is never sticky and never generates an interrupt.
- Read data:
  - reg_rd_out[EVT_NUM-1:0] = (sticky & STICKY_MASK) | (evt_in & ~STICKY_MASK).
  - Upper bits [REG_WIDTH-1:EVT_NUM] are tied to 0.
  - Valid in the same cycle as sel; the value is independent of sel.
- Interrupt:
  - irq <= |(sticky & STICKY_MASK & mask), registered, so 1 cycle after the sticky bit is visible.
  - Mask update on irq_en_wr takes effect on irq the cycle after the mask loads.
- Repeated events while a bit is already set: no effect.
- A W1C write of a bit that is already 0: no effect.
- Reset mid-operation clears all state immediately. No strobe is generated for a transaction interrupted by reset.

Optional Feature:
- Macro: REG_STATUS_RC_EN.
- Defined:
  - Sticky bits also clear on reg_read (read-to-clear).
  - reg_rd_out returns the pre-clear value in that cycle.
  - Priority remains rise > clear.
  - W1C still works.
- Not defined:
  - Reads are side-effect free.
  - Only W1C clears sticky bits.

Decomposition:
- Shared package reg_pkg:
  - REG_WIDTH default constant.
  - Access-type enum (RO, W1C, RC).
  - Strobe decode helper constants.
- One natural sub-module: field_w1c_evt, a single sticky bit with:
  - edge detect
  - set priority
  - W1C/RC clear
- Instantiate field_w1c_evt per bit with a generate loop gated by STICKY_MASK.
- Live bits reuse the existing read-only field.

Test Plan:
- Reset release with evt_in = 8'h01, STICKY_MASK = 8'hFF:
  - Bit0 sticky = 1 the next cycle; reg_rd_out = 32'h1.
  - irq = 0 while the mask is 0.
- Pulse evt_in[3] for 1 cycle, irq_en_data = 8'h08 loaded:
  - reg_rd_out[3] = 1 and stays 1 after evt_in drops.
  - irq = 1 one cycle later.
- Write 32'h08 (sel = 1, wr_rd = 1):
  - Bit3 = 0 the next cycle; status_wr pulses 1 cycle.
  - irq deasserts the cycle after.
- Rising edge on evt_in[2] in the same cycle as W1C 32'h04:
  - Bit2 remains 1.
- STICKY_MASK = 8'h0F, evt_in[5] toggles 0/1/0:
  - reg_rd_out[5] follows live; a write of 32'h20 has no effect; irq never asserts for bit5.
- With REG_STATUS_RC_EN, bit1 set, read:
  - reg_rd_out = 32'h2 in the read cycle; status_rd pulses.
  - Next read returns 32'h0.

Source files
------------

// File: rtl/reg_pkg.sv
// Shared definitions for field-based registers on the register-bank bus:
// default data width, field access types and the select/read/write decode.
package reg_pkg;

  localparam int REG_WIDTH_DEF = 32;

  // Field access types used by the register bank.
  typedef enum logic [1:0] {
    ACC_RO  = 2'd0,
    ACC_W1C = 2'd1,
    ACC_RC  = 2'd2
  } access_e;

  // Encoding of reg_wr_rd on the bus.
  localparam logic BUS_WRITE = 1'b1;
  localparam logic BUS_READ  = 1'b0;

  function automatic logic strobe_write(input logic sel, input logic wr_rd);
    return sel & (wr_rd == BUS_WRITE);
  endfunction

  function automatic logic strobe_read(input logic sel, input logic wr_rd);
    return sel & (wr_rd == BUS_READ);
  endfunction

endpackage

// File: rtl/reg_register_evt_status_field_w1c_evt.sv
// Single sticky event bit: rising-edge detect on evt, set has priority over
// clear. ACCESS = ACC_RC additionally clears the bit on a register read.
module field_w1c_evt
  import reg_pkg::*;
#(
  parameter access_e ACCESS = ACC_W1C
) (
  input  logic clk,
  input  logic rst_n,
  input  logic evt,
  input  logic wr_clr,
  input  logic rd_clr,
  output logic status
);

  logic evt_q;
  logic rise;
  logic clr;

  assign rise = evt & ~evt_q;
  assign clr  = wr_clr | ((ACCESS == ACC_RC) ? rd_clr : 1'b0);

  // Edge-detect history and sticky status; a coincident set wins over clear
  // so an event can never be lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      evt_q  <= 1'b0;
      status <= 1'b0;
    end else begin
      evt_q <= evt;
      if (rise) begin
        status <= 1'b1;
      end else if (clr) begin
        status <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/reg_register_evt_status.sv
// Event/status register: per-bit sticky (W1C) events or live read-only
// levels, masked registered interrupt and one-cycle read/write strobes.
// Optional macro REG_STATUS_RC_EN: sticky bits also clear on read.
module reg_register_evt_status
  import reg_pkg::*;
#(
  parameter int                 REG_WIDTH    = REG_WIDTH_DEF,
  parameter int                 EVT_NUM      = 8,
  parameter logic [EVT_NUM-1:0] STICKY_MASK  = {EVT_NUM{1'b1}},
  parameter logic [EVT_NUM-1:0] IRQ_MASK_RST = {EVT_NUM{1'b0}}
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [EVT_NUM-1:0]   evt_in,
  input  logic                 irq_en_wr,
  input  logic [EVT_NUM-1:0]   irq_en_data,
  input  logic                 reg_wr_sel,
  input  logic                 reg_wr_rd,
  input  logic [REG_WIDTH-1:0] reg_wr_data,
  output logic [REG_WIDTH-1:0] reg_rd_out,
  output logic                 status_rd,
  output logic                 status_wr,
  output logic                 irq
);

`ifdef REG_STATUS_RC_EN
  localparam access_e STICKY_ACCESS = ACC_RC;
`else
  localparam access_e STICKY_ACCESS = ACC_W1C;
`endif

  logic               reg_write;
  logic               reg_read;
  logic [EVT_NUM-1:0] sticky;
  logic [EVT_NUM-1:0] irq_mask;
  logic [EVT_NUM-1:0] rd_bits;
  logic               unused_wr_data;

  assign reg_write = strobe_write(reg_wr_sel, reg_wr_rd);
  assign reg_read  = strobe_read(reg_wr_sel, reg_wr_rd);

  // Only the sticky positions consume write data; the rest is don't-care.
  assign unused_wr_data = ^reg_wr_data;

  for (genvar i = 0; i < EVT_NUM; i++) begin : g_bit
    if (STICKY_MASK[i]) begin : g_sticky
      field_w1c_evt #(
        .ACCESS (STICKY_ACCESS)
      ) u_field (
        .clk    (clk),
        .rst_n  (rst_n),
        .evt    (evt_in[i]),
        .wr_clr (reg_write & reg_wr_data[i]),
        .rd_clr (reg_read),
        .status (sticky[i])
      );
    end else begin : g_live
      // Live level: no storage, read straight from evt_in.
      assign sticky[i] = 1'b0;
    end
  end

  assign rd_bits = (sticky & STICKY_MASK) | (evt_in & ~STICKY_MASK);

  // Read data is independent of select; upper bits read as zero.
  always_comb begin
    reg_rd_out              = '0;
    reg_rd_out[EVT_NUM-1:0] = rd_bits;
  end

  // Interrupt-enable mask register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_mask <= IRQ_MASK_RST;
    end else if (irq_en_wr) begin
      irq_mask <= irq_en_data;
    end
  end

  // Registered strobes and interrupt.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      status_rd <= 1'b0;
      status_wr <= 1'b0;
      irq       <= 1'b0;
    end else begin
      status_rd <= reg_read;
      status_wr <= reg_write;
      irq       <= |(sticky & STICKY_MASK & irq_mask);
    end
  end

endmodule

// File: tb/tb_reg_register_evt_status.sv
// Directed bench for reg_register_evt_status: one all-sticky instance and
// one mixed sticky/live instance (bits 3:0 sticky, 7:4 live, mask reset FF).
module tb_reg_register_evt_status;

`ifdef REG_STATUS_RC_EN
  localparam bit RC = 1'b1;
`else
  localparam bit RC = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  evt_in, irq_en_data;
  logic        irq_en_wr, sel, wr_rd;
  logic [31:0] wr_data, rd_out;
  logic        status_rd, status_wr, irq;

  logic [7:0]  l_evt, l_en_data;
  logic        l_en_wr, l_sel, l_wr_rd;
  logic [31:0] l_wr_data, l_rd_out;
  logic        l_status_rd, l_status_wr, l_irq;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  reg_register_evt_status u_dut (
    .clk(clk), .rst_n(rst_n), .evt_in(evt_in), .irq_en_wr(irq_en_wr),
    .irq_en_data(irq_en_data), .reg_wr_sel(sel), .reg_wr_rd(wr_rd),
    .reg_wr_data(wr_data), .reg_rd_out(rd_out), .status_rd(status_rd),
    .status_wr(status_wr), .irq(irq)
  );

  reg_register_evt_status #(
    .STICKY_MASK(8'h0F), .IRQ_MASK_RST(8'hFF)
  ) u_live (
    .clk(clk), .rst_n(rst_n), .evt_in(l_evt), .irq_en_wr(l_en_wr),
    .irq_en_data(l_en_data), .reg_wr_sel(l_sel), .reg_wr_rd(l_wr_rd),
    .reg_wr_data(l_wr_data), .reg_rd_out(l_rd_out), .status_rd(l_status_rd),
    .status_wr(l_status_wr), .irq(l_irq)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; evt_in = 8'h01; irq_en_wr = 0; irq_en_data = 0;
    sel = 0; wr_rd = 0; wr_data = 0;
    l_evt = 8'h20; l_en_wr = 0; l_en_data = 0; l_sel = 0; l_wr_rd = 0; l_wr_data = 0;
    step(); step();
    n_checks++; if (rd_out !== 32'h0) begin n_fail++; $display("FAIL reset_rd got %h exp %h", rd_out, 32'h0); end
    n_checks++; if ({irq, status_rd, status_wr} !== 3'b000) begin n_fail++; $display("FAIL reset_out got %b exp 000", {irq, status_rd, status_wr}); end
    n_checks++; if (l_rd_out !== 32'h20) begin n_fail++; $display("FAIL reset_live_rd got %h exp %h", l_rd_out, 32'h20); end
    rst_n = 1'b1;
    step();
    n_checks++; if (rd_out !== 32'h1) begin n_fail++; $display("FAIL first_rise got %h exp %h", rd_out, 32'h1); end
    step();
    n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_masked got %b exp 0", irq); end
  endtask

  task automatic test_event_irq();
    evt_in = 8'h09; irq_en_wr = 1; irq_en_data = 8'h08;
    step();
    evt_in = 8'h01; irq_en_wr = 0;
    n_checks++; if (rd_out !== 32'h09) begin n_fail++; $display("FAIL evt3_set got %h exp %h", rd_out, 32'h09); end
    n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_early got %b exp 0", irq); end
    step();
    n_checks++; if (rd_out !== 32'h09) begin n_fail++; $display("FAIL evt3_sticky got %h exp %h", rd_out, 32'h09); end
    n_checks++; if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_assert got %b exp 1", irq); end
  endtask

  task automatic test_w1c();
    sel = 1; wr_rd = 1; wr_data = 32'h08;
    #1;
    n_checks++; if (rd_out !== 32'h09) begin n_fail++; $display("FAIL w1c_pre got %h exp %h", rd_out, 32'h09); end
    step();
    sel = 0; wr_rd = 0; wr_data = 0;
    n_checks++; if (rd_out !== 32'h01) begin n_fail++; $display("FAIL w1c_clear got %h exp %h", rd_out, 32'h01); end
    n_checks++; if (status_wr !== 1'b1) begin n_fail++; $display("FAIL status_wr_pulse got %b exp 1", status_wr); end
    n_checks++; if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_hold got %b exp 1", irq); end
    step();
    n_checks++; if (status_wr !== 1'b0) begin n_fail++; $display("FAIL status_wr_end got %b exp 0", status_wr); end
    n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_deassert got %b exp 0", irq); end
  endtask

  task automatic test_set_clear_collision();
    evt_in = 8'h05; sel = 1; wr_rd = 1; wr_data = 32'h04;
    step();
    n_checks++; if (rd_out !== 32'h05) begin n_fail++; $display("FAIL set_wins got %h exp %h", rd_out, 32'h05); end
    wr_data = 32'h10;
    step();
    n_checks++; if (rd_out !== 32'h05) begin n_fail++; $display("FAIL w1c_zero_bit got %h exp %h", rd_out, 32'h05); end
    wr_data = 32'h04;
    step();
    sel = 0; wr_rd = 0; wr_data = 0;
    n_checks++; if (rd_out !== 32'h01) begin n_fail++; $display("FAIL clear_held_evt got %h exp %h", rd_out, 32'h01); end
    step();
    n_checks++; if (rd_out !== 32'h01) begin n_fail++; $display("FAIL no_rerise got %h exp %h", rd_out, 32'h01); end
  endtask

  task automatic test_mask_change();
    irq_en_wr = 1; irq_en_data = 8'h01;
    step();
    irq_en_wr = 0;
    n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL mask_load_lat got %b exp 0", irq); end
    step();
    n_checks++; if (irq !== 1'b1) begin n_fail++; $display("FAIL mask_enable got %b exp 1", irq); end
    irq_en_wr = 1; irq_en_data = 8'h00;
    step();
    irq_en_wr = 0;
    n_checks++; if (irq !== 1'b1) begin n_fail++; $display("FAIL mask_off_lat got %b exp 1", irq); end
    step();
    n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL mask_disable got %b exp 0", irq); end
  endtask

  task automatic test_read();
    logic [31:0] exp_v;
    evt_in = 8'h03;
    step();
    evt_in = 8'h11; sel = 1; wr_rd = 0;
    #1;
    n_checks++; if (rd_out !== 32'h03) begin n_fail++; $display("FAIL read_pre got %h exp %h", rd_out, 32'h03); end
    step();
    exp_v = RC ? 32'h10 : 32'h13;
    n_checks++; if (rd_out !== exp_v) begin n_fail++; $display("FAIL read1_after got %h exp %h", rd_out, exp_v); end
    n_checks++; if (status_rd !== 1'b1) begin n_fail++; $display("FAIL status_rd_pulse got %b exp 1", status_rd); end
    n_checks++; if (status_wr !== 1'b0) begin n_fail++; $display("FAIL read_no_wr got %b exp 0", status_wr); end
    step();
    sel = 0;
    exp_v = RC ? 32'h00 : 32'h13;
    n_checks++; if (rd_out !== exp_v) begin n_fail++; $display("FAIL read2_after got %h exp %h", rd_out, exp_v); end
    step();
    n_checks++; if (status_rd !== 1'b0) begin n_fail++; $display("FAIL status_rd_end got %b exp 0", status_rd); end
  endtask

  task automatic test_live();
    l_evt = 8'h00;
    #1;
    n_checks++; if (l_rd_out !== 32'h0) begin n_fail++; $display("FAIL live_low got %h exp %h", l_rd_out, 32'h0); end
    step();
    l_evt = 8'h20;
    #1;
    n_checks++; if (l_rd_out !== 32'h20) begin n_fail++; $display("FAIL live_high got %h exp %h", l_rd_out, 32'h20); end
    step(); step();
    n_checks++; if (l_irq !== 1'b0) begin n_fail++; $display("FAIL live_no_irq got %b exp 0", l_irq); end
    l_evt = 8'h21;
    step();
    n_checks++; if (l_irq !== 1'b0) begin n_fail++; $display("FAIL mixed_irq_lat got %b exp 0", l_irq); end
    step();
    n_checks++; if (l_irq !== 1'b1) begin n_fail++; $display("FAIL mixed_irq_rst_mask got %b exp 1", l_irq); end
    l_sel = 1; l_wr_rd = 1; l_wr_data = 32'h20;
    step();
    l_sel = 0; l_wr_rd = 0; l_wr_data = 0;
    n_checks++; if (l_rd_out !== 32'h21) begin n_fail++; $display("FAIL live_write_ignored got %h exp %h", l_rd_out, 32'h21); end
    l_evt = 8'h01;
    #1;
    n_checks++; if (l_rd_out !== 32'h01) begin n_fail++; $display("FAIL live_follow got %h exp %h", l_rd_out, 32'h01); end
  endtask

  task automatic test_async_reset();
    evt_in = 8'h40;
    step();
    sel = 1; wr_rd = 1; wr_data = 32'hFF;
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++; if (rd_out !== 32'h0) begin n_fail++; $display("FAIL async_clear got %h exp %h", rd_out, 32'h0); end
    n_checks++; if (l_irq !== 1'b0) begin n_fail++; $display("FAIL async_irq got %b exp 0", l_irq); end
    step();
    sel = 0; wr_rd = 0; wr_data = 0; evt_in = 8'h00;
    rst_n = 1'b1;
    step();
    n_checks++; if (status_wr !== 1'b0) begin n_fail++; $display("FAIL no_strobe_after_rst got %b exp 0", status_wr); end
  endtask

  initial begin
    test_reset();
    test_event_irq();
    test_w1c();
    test_set_clear_collision();
    test_mask_change();
    test_read();
    test_live();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
